// File: rtl/xilinx_ultraram_dual_port_pipelined.sv
// True dual-port byte-writable RAM with per-port read-during-write modes,
// an NBPIPE-deep valid-tracked read pipeline and a gated output register.

module xilinx_ultraram_dual_port_pipelined_port #(
  parameter int NUM_COL = 9,
  parameter int CWIDTH  = 8,
  parameter int DWIDTH  = 72,
  parameter int NBPIPE  = 3,
  parameter int MODE    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [NUM_COL-1:0] we_i,
  input  logic [DWIDTH-1:0]  din_i,
  input  logic [DWIDTH-1:0]  rdata_i,
  input  logic               regce_i,
  output logic [DWIDTH-1:0]  dout_o,
  output logic               dout_valid_o
);
  logic                          rd_op;
  logic [DWIDTH-1:0]             word_d;
  logic [NBPIPE:0]               vld_pipe_q;
  logic [NBPIPE:0][DWIDTH-1:0]   data_pipe_q;
  logic [DWIDTH-1:0]             dout_q;
  logic                          dout_valid_q;

  // NO_CHANGE write cycles never enter the pipeline
  assign rd_op = en_i && ((we_i == '0) || (MODE != 0));

  always_comb begin
    word_d = rdata_i;
    if (MODE == 2)
      for (int c = 0; c < NUM_COL; c++)
        if (we_i[c]) word_d[c*CWIDTH +: CWIDTH] = din_i[c*CWIDTH +: CWIDTH];
  end

  // data stages carry no reset; a stage only moves when its predecessor is valid
  always_ff @(posedge clk) begin
    if (rd_op) data_pipe_q[0] <= word_d;
    for (int i = 1; i <= NBPIPE; i++)
      if (vld_pipe_q[i-1]) data_pipe_q[i] <= data_pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      vld_pipe_q   <= {vld_pipe_q[NBPIPE-1:0], rd_op};
      dout_valid_q <= vld_pipe_q[NBPIPE] && regce_i;
      if (vld_pipe_q[NBPIPE] && regce_i) dout_q <= data_pipe_q[NBPIPE];
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
endmodule

module xilinx_ultraram_dual_port_pipelined #(
  parameter int AWIDTH  = 12,
  parameter int NUM_COL = 9,
  parameter int CWIDTH  = 8,
  parameter int DWIDTH  = 72,
  parameter int NBPIPE  = 3,
  parameter int MODE_A  = 0,
  parameter int MODE_B  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_a,
  input  logic [NUM_COL-1:0] we_a,
  input  logic [AWIDTH-1:0]  addr_a,
  input  logic [DWIDTH-1:0]  din_a,
  input  logic               regce_a,
  output logic [DWIDTH-1:0]  dout_a,
  output logic               dout_valid_a,
  input  logic               en_b,
  input  logic [NUM_COL-1:0] we_b,
  input  logic [AWIDTH-1:0]  addr_b,
  input  logic [DWIDTH-1:0]  din_b,
  input  logic               regce_b,
  output logic [DWIDTH-1:0]  dout_b,
  output logic               dout_valid_b
);
  if (DWIDTH != NUM_COL*CWIDTH) begin : g_err_dw
    $error("DWIDTH must equal NUM_COL*CWIDTH");
  end
  if (NBPIPE < 1 || NBPIPE > 8) begin : g_err_pipe
    $error("NBPIPE must be in 1..8");
  end
  if (MODE_A < 0 || MODE_A > 2 || MODE_B < 0 || MODE_B > 2) begin : g_err_mode
    $error("MODE_A/MODE_B must be 0, 1 or 2");
  end

  (* ram_style = "ultra" *) logic [DWIDTH-1:0] mem_q [2**AWIDTH];
  logic [DWIDTH-1:0] rdata_a, rdata_b;

  // B is applied first so A's column wins on a same-address collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (en_b && we_b[c]) mem_q[addr_b][c*CWIDTH +: CWIDTH] <= din_b[c*CWIDTH +: CWIDTH];
        if (en_a && we_a[c]) mem_q[addr_a][c*CWIDTH +: CWIDTH] <= din_a[c*CWIDTH +: CWIDTH];
      end
    end
  end

  assign rdata_a = mem_q[addr_a];
  assign rdata_b = mem_q[addr_b];

  xilinx_ultraram_dual_port_pipelined_port #(
    .NUM_COL(NUM_COL), .CWIDTH(CWIDTH), .DWIDTH(DWIDTH), .NBPIPE(NBPIPE), .MODE(MODE_A)
  ) u_port_a (
    .clk(clk), .rst(rst), .en_i(en_a), .we_i(we_a), .din_i(din_a), .rdata_i(rdata_a),
    .regce_i(regce_a), .dout_o(dout_a), .dout_valid_o(dout_valid_a)
  );

  xilinx_ultraram_dual_port_pipelined_port #(
    .NUM_COL(NUM_COL), .CWIDTH(CWIDTH), .DWIDTH(DWIDTH), .NBPIPE(NBPIPE), .MODE(MODE_B)
  ) u_port_b (
    .clk(clk), .rst(rst), .en_i(en_b), .we_i(we_b), .din_i(din_b), .rdata_i(rdata_b),
    .regce_i(regce_b), .dout_o(dout_b), .dout_valid_o(dout_valid_b)
  );
endmodule

// File: tb/tb_xilinx_ultraram_dual_port_pipelined.sv
// Two instances (WRITE_FIRST/NO_CHANGE and READ_FIRST/READ_FIRST) share stimulus
// and are compared every cycle against a latency-scheduled memory model.

module tb_xilinx_ultraram_dual_port_pipelined;
  localparam int AW = 12, NC = 9, CW = 8, DW = 72, NP = 3, L = NP + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en_a, en_b, regce_a, regce_b;
  logic [NC-1:0] we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;
  logic [DW-1:0] d0a, d0b, d1a, d1b;
  logic          v0a, v0b, v1a, v1b;

  xilinx_ultraram_dual_port_pipelined #(
    .AWIDTH(AW), .NUM_COL(NC), .CWIDTH(CW), .DWIDTH(DW), .NBPIPE(NP), .MODE_A(2), .MODE_B(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .regce_a(regce_a),
    .dout_a(d0a), .dout_valid_a(v0a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .regce_b(regce_b),
    .dout_b(d0b), .dout_valid_b(v0b)
  );

  xilinx_ultraram_dual_port_pipelined #(
    .AWIDTH(AW), .NUM_COL(NC), .CWIDTH(CW), .DWIDTH(DW), .NBPIPE(NP), .MODE_A(1), .MODE_B(1)
  ) u_dut_rf (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .regce_a(regce_a),
    .dout_a(d1a), .dout_valid_a(v1a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .regce_b(regce_b),
    .dout_b(d1b), .dout_valid_b(v1b)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  int    modes [4] = '{2, 0, 1, 1};
  string pn    [4] = '{"wf.a", "nc.b", "rf.a", "rf.b"};
  logic [DW-1:0] mem_m  [64];
  logic [DW-1:0] init_d [64];
  bit            ring_v [4][8];
  logic [DW-1:0] ring_d [4][8];
  bit            exp_v  [4];
  logic [DW-1:0] exp_d  [4];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Results are booked for the edge L cycles after issue; reset cancels bookings.
  task automatic model_edge();
    logic          en, rg;
    logic [NC-1:0] we;
    logic [DW-1:0] din, w;
    int            ad, s;
    s = cyc % 8;
    for (int p = 0; p < 4; p++) begin
      en  = (p % 2 == 0) ? en_a : en_b;
      we  = (p % 2 == 0) ? we_a : we_b;
      din = (p % 2 == 0) ? din_a : din_b;
      rg  = (p % 2 == 0) ? regce_a : regce_b;
      ad  = (p % 2 == 0) ? int'(addr_a[5:0]) : int'(addr_b[5:0]);
      if (rst) begin
        exp_v[p] = 1'b0;
        exp_d[p] = '0;
        for (int k = 0; k < 8; k++) ring_v[p][k] = 1'b0;
      end else begin
        exp_v[p] = 1'b0;
        if (ring_v[p][s]) begin
          ring_v[p][s] = 1'b0;
          if (rg) begin
            exp_v[p] = 1'b1;
            exp_d[p] = ring_d[p][s];
          end
        end
        if (en && (we == '0 || modes[p] != 0)) begin
          w = mem_m[ad];
          if (modes[p] == 2)
            for (int c = 0; c < NC; c++)
              if (we[c]) w[c*CW +: CW] = din[c*CW +: CW];
          ring_v[p][(cyc + L) % 8] = 1'b1;
          ring_d[p][(cyc + L) % 8] = w;
        end
      end
    end
    if (!rst) begin
      for (int c = 0; c < NC; c++)
        if (en_b && we_b[c]) mem_m[addr_b[5:0]][c*CW +: CW] = din_b[c*CW +: CW];
      for (int c = 0; c < NC; c++)
        if (en_a && we_a[c]) mem_m[addr_a[5:0]][c*CW +: CW] = din_a[c*CW +: CW];
    end
    cyc++;
  endtask

  task automatic tick();
    logic [DW-1:0] od [4];
    logic          ov [4];
    @(posedge clk);
    model_edge();
    #1;
    od = '{d0a, d0b, d1a, d1b};
    ov = '{v0a, v0b, v1a, v1b};
    for (int p = 0; p < 4; p++) begin
      chk({pn[p], ".dout"}, od[p], exp_d[p]);
      chk({pn[p], ".valid"}, {71'b0, ov[p]}, {71'b0, exp_v[p]});
    end
  endtask

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
  endtask

  initial begin
    rst = 1'b1; idle();
    regce_a = 1'b0; regce_b = 1'b0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    tick(); tick();
    rst = 1'b0;

    // preload 0..63 with regce low so reads of unwritten words never land
    for (int i = 0; i < 64; i++) begin
      init_d[i] = (i == 5) ? {9{8'h77}} : (i == 7) ? {9{8'h22}} : (i == 32) ? '0 : rnd();
      en_a = 1'b1; we_a = '1; addr_a = AW'(i); din_a = init_d[i];
      tick();
    end
    idle();
    repeat (6) tick();
    regce_a = 1'b1; regce_b = 1'b1;

    // full write on A then plain read on B, latency L
    en_a = 1'b1; we_a = '1; addr_a = 12'h010; din_a = 72'h0123456789ABCDEF01;
    tick();
    idle(); en_b = 1'b1; addr_b = 12'h010;
    tick();
    idle();
    repeat (3) tick();
    tick();
    chk("t1.dout_b", d0b, 72'h0123456789ABCDEF01);
    chk("t1.valid_b", {71'b0, v0b}, 72'd1);
    tick();
    chk("t1.valid_b_off", {71'b0, v0b}, 72'd0);

    // WRITE_FIRST/READ_FIRST partial write; concurrent NO_CHANGE write on B
    en_a = 1'b1; we_a = 9'h003; addr_a = 12'h020; din_a = {56'hDEADBEEFCAFEF0, 16'hBEEF};
    en_b = 1'b1; we_b = '1; addr_b = 12'h021; din_b = rnd();
    tick();
    idle();
    repeat (3) tick();
    tick();
    chk("t2.wf_dout_a", d0a, 72'h00000000000000BEEF);
    chk("t2.wf_valid_a", {71'b0, v0a}, 72'd1);
    chk("t2.rf_dout_a", d1a, 72'h0);
    chk("t2.nc_valid_b", {71'b0, v0b}, 72'd0);

    // same-address collision, A wins overlapping columns
    en_a = 1'b1; we_a = 9'h00F; addr_a = 12'd5; din_a = {9{8'hAA}};
    en_b = 1'b1; we_b = 9'h0FF; addr_b = 12'd5; din_b = {9{8'h55}};
    tick();
    idle(); en_b = 1'b1; addr_b = 12'd5;
    tick();
    idle();
    repeat (3) tick();
    tick();
    chk("t3.collide", d0b, 72'h7755555555AAAAAAAA);

    // cross-port read sees pre-write word, next cycle sees new word
    en_a = 1'b1; we_a = '1; addr_a = 12'd7; din_a = {9{8'h11}};
    en_b = 1'b1; addr_b = 12'd7;
    tick();
    idle(); en_b = 1'b1; addr_b = 12'd7;
    tick();
    idle();
    repeat (2) tick();
    tick();
    chk("t4.old", d0b, {9{8'h22}});
    tick();
    chk("t4.new", d0b, {9{8'h11}});

    // back-to-back reads with one landing dropped by regce
    for (int t = 0; t < 14; t++) begin
      en_b = (t < 10); we_b = '0; addr_b = AW'(t); regce_b = (t != 7);
      tick();
      if (t == 7) begin
        chk("t5.drop_valid", {71'b0, v0b}, 72'd0);
        chk("t5.hold", d0b, init_d[2]);
      end
    end
    regce_b = 1'b1; idle();

    // reset with reads in flight and a write during reset
    for (int t = 0; t < 3; t++) begin
      en_a = 1'b1; we_a = '0; addr_a = AW'(48 + t);
      en_b = 1'b1; addr_b = AW'(49 + t);
      if (t == 2) begin
        rst = 1'b1; we_a = '1; addr_a = 12'h033; din_a = ~init_d[51];
      end
      tick();
    end
    chk("t6.rst_dout", d0a, 72'h0);
    chk("t6.rst_valid", {71'b0, v0a}, 72'd0);
    rst = 1'b0; idle();
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("t6.no_valid", {70'b0, v0a, v0b}, 72'd0);
    end
    en_b = 1'b1; addr_b = 12'h033;
    tick();
    idle();
    repeat (3) tick();
    tick();
    chk("t6.mem_kept", d0b, init_d[51]);

    // randomized traffic on a small address window to provoke collisions
    repeat (1500) begin
      rst     = ($urandom_range(0, 99) == 0);
      en_a    = ($urandom_range(0, 9) < 7);
      en_b    = ($urandom_range(0, 9) < 7);
      we_a    = ($urandom_range(0, 2) == 0) ? '0 : NC'($urandom);
      we_b    = ($urandom_range(0, 2) == 0) ? '0 : NC'($urandom);
      addr_a  = AW'($urandom_range(0, 15));
      addr_b  = AW'($urandom_range(0, 15));
      din_a   = rnd();
      din_b   = rnd();
      regce_a = ($urandom_range(0, 9) != 0);
      regce_b = ($urandom_range(0, 9) != 0);
      tick();
    end
    rst = 1'b0; idle(); regce_a = 1'b1; regce_b = 1'b1;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/xilinx_ultraram_dual_port_pipelined.md
Name: xilinx_ultraram_dual_port_pipelined

Overview:
- True dual-port UltraRAM block with independent ports A and B on one clock.
- Each port has per-column write enables, a configurable read-during-write mode (NO_CHANGE / READ_FIRST / WRITE_FIRST), an NBPIPE-deep output pipeline, and a per-port dout_valid strobe.
- Defined byte-level collision rules between the two ports.
- Used as the deep on-chip buffer behind AXI/DMA adapters that need concurrent read and write streams with tracked read returns.

Parameters:
AWIDTH, 12, address width; depth = 2**AWIDTH words
NUM_COL, 9, number of byte columns per word
CWIDTH, 8, column width in bits
DWIDTH, 72, data width; must equal NUM_COL*CWIDTH
NBPIPE, 3, output pipeline registers per port; legal range 1..8
MODE_A, 0, port A read-during-write mode: 0=NO_CHANGE, 1=READ_FIRST, 2=WRITE_FIRST
MODE_B, 0, port B read-during-write mode, same encoding

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en_a  in  1  port A operation enable
we_a  in  NUM_COL  port A column write enables
addr_a  in  AWIDTH  port A address
din_a  in  DWIDTH  port A write data
regce_a  in  1  port A final output register enable
dout_a  out  DWIDTH  port A read data
dout_valid_a  out  1  port A read data valid strobe
en_b, we_b, addr_b, din_b, regce_b, dout_b, dout_valid_b  as port A, for port B

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset values: while rst is high, dout_a = dout_b = 0 and dout_valid_a = dout_valid_b = 0. All pipeline valid bits clear; pipeline data registers need not clear.
- Memory contents are never reset. Memory writes are suppressed in any cycle with rst=1.
- Reset mid-operation: reads in flight when rst is asserted are discarded. No dout_valid may appear for them after rst deasserts.
- Write: at a rising edge with en=1, each column i with we[i]=1 gets din[i*CWIDTH +: CWIDTH]. Other columns are unchanged.
- Read-producing op, per port:
  - en=1 and we==0, any mode, OR
  - en=1 and we!=0 with mode READ_FIRST or WRITE_FIRST.
  - NO_CHANGE write cycles produce no read. Output and valid pipelines are untouched.
- Read data content for a read-producing op:
  - Plain read: the stored word.
  - READ_FIRST write: the word before the write.
  - WRITE_FIRST write: the pre-write word with this port's enabled columns replaced by din.
- Latency: an op sampled at edge k updates dout/dout_valid at edge k+NBPIPE+1. Stage order is array read register, then NBPIPE pipeline stages, then the output register. With NBPIPE=3, results appear at edge k+4.
- Throughput: one op per port per cycle, no bubbles. Pipeline stages advance only when their valid bit is set.
- Output register, per port: at the landing edge, if the valid bit is set and regce=1, dout loads and dout_valid=1 for exactly one cycle.
  - If regce=0 at the landing edge, the result is dropped: dout holds and dout_valid=0.
  - dout_valid=0 on every edge with no landing result.
  - dout holds its last value between results.
- Collision, both ports write the same address in the same cycle: per column, A's data wins where both enable that column. The stored word is the union of both ports' writes.
- Cross-port read vs write, same address, same cycle: the reading port returns the pre-write word. Each port's WRITE_FIRST merge uses only its own din/we.
- Address width: addr is used as-is; every value is in range, no wrap logic.
- Elaboration errors: DWIDTH != NUM_COL*CWIDTH, NBPIPE outside 1..8, or MODE_x > 2.
- Synthesis attribute: ram_style "ultra" on the array.

Test Plan:
- Defaults. Write A addr 0x010 din 0x0123456789ABCDEF01, we=9'h1FF, then read B addr 0x010 at edge k -> dout_b=0x0123456789ABCDEF01, dout_valid_b=1 at edge k+4 only.
- Byte merge and WRITE_FIRST. Memory[0x20]=0x00...00, MODE_A=2. Write A we=9'h003 din=0x...BEEF -> dout_a=0x000000000000000000BEEF-masked word (low 2 bytes 0xBEEF, rest 0) at latency; READ_FIRST variant returns 0. NO_CHANGE variant gives no dout_valid_a.
- Collision. Same cycle, A writes addr 5 we=9'h00F din all-0xAA; B writes addr 5 we=9'h0FF din all-0x55 -> readback = bytes0-3 0xAA, bytes4-7 0x55, byte8 unchanged.
- Cross-port read. A writes addr 7 = 0x11..11 (prior content 0x22..22) while B reads addr 7 the same cycle -> dout_b=0x22..22. B read next cycle -> 0x11..11.
- Back-to-back plus regce. Ten consecutive B reads of addrs 0..9 -> ten consecutive dout_valid_b pulses in order. regce_b=0 on the 4th landing edge -> that result is dropped, and dout_b holds the 3rd result.
- Reset mid-flight. Issue 3 reads, assert rst for 1 cycle at edge k+2 -> dout=0, dout_valid=0 during rst, and no valid pulses afterwards. A write issued in the rst cycle does not change memory.
